// File: rtl/sobel_row_loader.sv
// Row loader feeding the sequential Sobel PE array.
// Collects a raster pixel stream into two ping-pong row banks. Each full bank
// is presented as one edge-padded parallel row, tagged with its row number
// and with first/last-row flags.
module sobel_row_loader #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int PIX_W      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PIX_W-1:0]                  pix_in,
    input  logic                              pix_valid,
    input  logic                              pix_sof,
    output logic                              pix_ready,
    output logic [(IMG_WIDTH+2)*PIX_W-1:0]    row_out,
    output logic                              row_valid,
    input  logic                              row_ready,
    output logic [$clog2(IMG_HEIGHT)-1:0]     row_index,
    output logic                              row_first,
    output logic                              row_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    logic [PIX_W-1:0] bank_pix [2][IMG_WIDTH];
    logic [1:0]       full;
    logic [RW-1:0]    tag [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [CW-1:0]    wcol;
    logic [RW-1:0]    wrow;
    logic             accept;
    logic             transfer;

    // Handshake qualifiers for both sides of the double buffer
    always_comb begin
        pix_ready = !full[wr_bank] && !rst;
        accept    = pix_valid && pix_ready;
        transfer  = full[rd_bank] && row_ready;
    end

    // Pixel storage: a start-of-frame beat always lands in column 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < IMG_WIDTH; i++) begin
                    bank_pix[b][CW'(i)] <= '0;
                end
            end
        end else if (accept) begin
            if (pix_sof) begin
                bank_pix[wr_bank][0] <= pix_in;
            end else begin
                bank_pix[wr_bank][wcol] <= pix_in;
            end
        end
    end

    // Write/read pointers, full flags and row tags.
    // A fill can only target a non-full bank and a transfer only a full one,
    // so both updates to 'full' in one cycle always touch different bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= '0;
            tag[0]  <= '0;
            tag[1]  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wcol    <= '0;
            wrow    <= '0;
        end else begin
            if (accept) begin
                if (pix_sof) begin
                    wcol <= CW'(1);
                    wrow <= '0;
                end else if (wcol == LAST_COL) begin
                    full[wr_bank] <= 1'b1;
                    tag[wr_bank]  <= wrow;
                    wr_bank       <= ~wr_bank;
                    wcol          <= '0;
                    wrow          <= (wrow == LAST_ROW) ? '0 : wrow + 1'b1;
                end else begin
                    wcol <= wcol + 1'b1;
                end
            end
            if (transfer) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // Present the read bank as an edge-replicated row
    always_comb begin
        row_valid = full[rd_bank];
        row_index = tag[rd_bank];
        row_first = row_valid && (tag[rd_bank] == '0);
        row_last  = row_valid && (tag[rd_bank] == LAST_ROW);
        row_out   = '0;
        row_out[0 +: PIX_W] = bank_pix[rd_bank][0];
        for (int unsigned k = 0; k < IMG_WIDTH; k++) begin
            row_out[(k + 1) * PIX_W +: PIX_W] = bank_pix[rd_bank][CW'(k)];
        end
        row_out[(IMG_WIDTH + 1) * PIX_W +: PIX_W] = bank_pix[rd_bank][LAST_COL];
    end

endmodule

// File: tb/tb_sobel_row_loader.sv
// Scoreboard bench for sobel_row_loader with a 4x3 image of 8-bit pixels.
module tb_sobel_row_loader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 8;

    logic            clk;
    logic            rst;
    logic [PW-1:0]   pix_in;
    logic            pix_valid;
    logic            pix_sof;
    logic            pix_ready;
    logic [(W+2)*PW-1:0] row_out;
    logic            row_valid;
    logic            row_ready;
    logic [1:0]      row_index;
    logic            row_first;
    logic            row_last;

    typedef struct packed {
        logic [(W+2)*PW-1:0] data;
        logic [1:0]          idx;
        logic                first;
        logic                last;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        t5_done;

    sobel_row_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
        .row_out(row_out), .row_valid(row_valid), .row_ready(row_ready),
        .row_index(row_index), .row_first(row_first), .row_last(row_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [(W+2)*PW-1:0] mk_row(input logic [7:0] a, input logic [7:0] b,
                                                    input logic [7:0] c, input logic [7:0] d);
        return {d, d, c, b, a, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_row(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [1:0] idx);
        exp_t e;
        e.data  = mk_row(a, b, c, d);
        e.idx   = idx;
        e.first = (idx == 2'd0);
        e.last  = (idx == 2'(H - 1));
        sb.push_back(e);
    endtask

    // Drives one pixel until accepted; returns the number of stalled cycles
    task automatic send_pix(input logic [7:0] v, input logic s, output int unsigned stalls);
        logic ok;
        stalls    = 0;
        ok        = 1'b0;
        pix_in    = v;
        pix_sof   = s;
        pix_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = pix_ready;
            @(posedge clk);
            #1;
            if (!ok) stalls++;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pixel %0d not accepted within 100 cycles", v);
        end
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 100 && sb.size() != 0; n++) begin
            @(posedge clk);
            #2;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compare every transferred row against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (row_valid && row_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_row: got %0h with no row expected", row_out);
                    end else begin
                        e = sb.pop_front();
                        check("row_data", 64'(row_out), 64'(e.data));
                        check("row_index", 64'(row_index), 64'(e.idx));
                        check("row_first", 64'(row_first), 64'(e.first));
                        check("row_last", 64'(row_last), 64'(e.last));
                    end
                end else if (!row_valid) begin
                    check("idle_flags", 64'({row_first, row_last}), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned st;
        int unsigned total;
        rst       = 1'b1;
        pix_in    = '0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        row_ready = 1'b0;
        t5_done   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_pix_ready", 64'(pix_ready), 64'd0);
        check("rst_row_valid", 64'(row_valid), 64'd0);
        check("rst_row_out", 64'(row_out), 64'd0);
        check("rst_row_index", 64'(row_index), 64'd0);
        check("rst_flags", 64'({row_first, row_last}), 64'd0);

        // Test 1: full-rate stream with row_ready held high
        do_reset();
        row_ready = 1'b1;
        push_row(1, 2, 3, 4, 0);
        push_row(5, 6, 7, 8, 1);
        push_row(9, 10, 11, 12, 2);
        total = 0;
        for (int i = 1; i <= 12; i++) begin
            send_pix(8'(i), i == 1, st);
            total += st;
            if (i % 4 == 3) check("latency_before", 64'(row_valid), 64'd0);
            if (i % 4 == 0) check("latency_after", 64'(row_valid), 64'd1);
        end
        check("no_bubbles", 64'(total), 64'd0);
        wait_drain("drain_t1");

        // Test 2: backpressure fills both banks
        do_reset();
        row_ready = 1'b0;
        push_row(1, 2, 3, 4, 0);
        push_row(5, 6, 7, 8, 1);
        for (int i = 1; i <= 8; i++) send_pix(8'(i), i == 1, st);
        check("bp_pix_ready_low", 64'(pix_ready), 64'd0);
        check("bp_row_valid", 64'(row_valid), 64'd1);
        pix_valid = 1'b1;
        for (int i = 9; i <= 10; i++) begin
            pix_in = 8'(i);
            @(negedge clk);
            check("bp_reject", 64'(pix_ready), 64'd0);
            check("bp_hold", 64'(row_out), 64'(mk_row(1, 2, 3, 4)));
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        row_ready = 1'b1;
        @(posedge clk);
        #1;
        row_ready = 1'b0;
        check("bp_next_row", 64'(row_out), 64'(mk_row(5, 6, 7, 8)));
        check("bp_next_index", 64'(row_index), 64'd1);
        check("bp_pix_ready_back", 64'(pix_ready), 64'd1);
        row_ready = 1'b1;
        wait_drain("drain_t2");

        // Test 3: start-of-frame discards a partial row
        do_reset();
        row_ready = 1'b1;
        push_row(20, 21, 22, 23, 0);
        send_pix(1, 1'b0, st);
        send_pix(2, 1'b0, st);
        send_pix(20, 1'b1, st);
        send_pix(21, 1'b0, st);
        send_pix(22, 1'b0, st);
        send_pix(23, 1'b0, st);
        wait_drain("drain_t3");

        // Test 4: reset mid-row with one row presented
        do_reset();
        row_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send_pix(8'(i), i == 1, st);
        check("pre_rst_valid", 64'(row_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(row_valid), 64'd0);
        check("mid_rst_pix_ready", 64'(pix_ready), 64'd0);
        check("mid_rst_row_out", 64'(row_out), 64'd0);
        check("mid_rst_index_flags", 64'({row_index, row_first, row_last}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_pix_ready", 64'(pix_ready), 64'd1);
        @(negedge clk);
        check("post_rst_no_row", 64'(row_valid), 64'd0);
        @(posedge clk);
        #1;
        row_ready = 1'b1;
        push_row(30, 31, 32, 33, 0);
        for (int i = 30; i <= 33; i++) send_pix(8'(i), i == 30, st);
        wait_drain("drain_t4");

        // Test 5: two frames with row_ready toggling every cycle
        do_reset();
        row_ready = 1'b1;
        for (int r = 0; r < 6; r++)
            push_row(8'(4*r+1), 8'(4*r+2), 8'(4*r+3), 8'(4*r+4), 2'(r % 3));
        fork
            begin
                for (int i = 1; i <= 24; i++) send_pix(8'(i), (i == 1) || (i == 13), st);
                wait_drain("drain_t5");
                t5_done = 1'b1;
            end
            begin
                for (int n = 0; n < 400 && !t5_done; n++) begin
                    @(posedge clk);
                    #1;
                    row_ready = ~row_ready;
                end
            end
        join
        row_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
